// File: rtl/median3x3_stream.sv
// Streaming 3x3 median filter with internal line buffers and end-of-frame flush.
// One output pixel per input pixel; border pixels pass through or are zeroed.
module median3x3_stream #(
  parameter int DATA_W      = 8,
  parameter int IMG_W       = 64,
  parameter int IMG_H       = 64,
  parameter int BORDER_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eol
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int NW = $clog2(IMG_W + 1);

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
  localparam logic [NW-1:0] CNT_END  = NW'(IMG_W);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  typedef logic [DATA_W-1:0] pix_t;

  function automatic pix_t f_min(input pix_t a, input pix_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic pix_t f_max(input pix_t a, input pix_t b);
    return (a < b) ? b : a;
  endfunction

  function automatic pix_t f_min3(input pix_t a, input pix_t b, input pix_t c);
    return f_min(f_min(a, b), c);
  endfunction

  function automatic pix_t f_max3(input pix_t a, input pix_t b, input pix_t c);
    return f_max(f_max(a, b), c);
  endfunction

  function automatic pix_t f_med3(input pix_t a, input pix_t b, input pix_t c);
    return f_max(f_min(a, b), f_min(f_max(a, b), c));
  endfunction

  logic [1:0]    r_state;
  logic          r_rdy;
  logic [NW-1:0] r_cnt;
  logic [CW-1:0] r_icol;
  logic [RW-1:0] r_irow;
  logic [CW-1:0] r_ocol;
  logic [RW-1:0] r_orow;

  logic r_req, r_req_sof, r_req_eol, r_req_bord;
  logic r_v1, r_sof1, r_eol1, r_bord1;
  logic r_v2, r_sof2, r_eol2, r_bord2;

  pix_t r_lb0 [IMG_W];
  pix_t r_lb1 [IMG_W];
  pix_t r_w   [3][3];
  pix_t r_mn  [3];
  pix_t r_md  [3];
  pix_t r_mx  [3];
  pix_t r_c1, r_c2;
  pix_t r_a, r_b, r_c;

  logic w_flush;
  logic w_step;
  logic w_emit;
  pix_t w_res;

  assign w_flush  = (r_state == S_FLUSH);
  assign in_ready = r_rdy & ~w_flush;
  assign w_step   = w_flush | (in_valid & in_ready);
  assign w_emit   = w_step & (r_state != S_FILL);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_FILL;
      r_rdy      <= 1'b0;
      r_cnt      <= '0;
      r_icol     <= '0;
      r_irow     <= '0;
      r_ocol     <= '0;
      r_orow     <= '0;
      r_req      <= 1'b0;
      r_req_sof  <= 1'b0;
      r_req_eol  <= 1'b0;
      r_req_bord <= 1'b0;
    end else begin
      r_rdy <= 1'b1;
      r_req <= w_emit;
      if (w_step) begin
        if (r_icol == LAST_COL) begin
          r_icol <= '0;
          if (!w_flush)
            r_irow <= (r_irow == LAST_ROW) ? '0 : r_irow + 1'b1;
        end else begin
          r_icol <= r_icol + 1'b1;
        end
      end
      unique case (r_state)
        S_FILL: begin
          if (w_step) begin
            if (r_cnt == CNT_END) begin
              r_state <= S_RUN;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_step && r_icol == LAST_COL && r_irow == LAST_ROW)
            r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (r_cnt == CNT_END) begin
            r_state <= S_FILL;
            r_cnt   <= '0;
            r_icol  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_FILL;
      endcase
      // Tag each request with its raster position before advancing
      if (w_emit) begin
        r_req_sof  <= (r_orow == '0) && (r_ocol == '0);
        r_req_eol  <= (r_ocol == LAST_COL);
        r_req_bord <= (r_orow == '0) || (r_orow == LAST_ROW) ||
                      (r_ocol == '0) || (r_ocol == LAST_COL);
        if (r_ocol == LAST_COL) begin
          r_ocol <= '0;
          r_orow <= (r_orow == LAST_ROW) ? '0 : r_orow + 1'b1;
        end else begin
          r_ocol <= r_ocol + 1'b1;
        end
      end
    end
  end

  // Line buffers rotate one column per step; window column 2 is newest
  always_ff @(posedge clk) begin
    if (w_step) begin
      r_lb0[r_icol] <= r_lb1[r_icol];
      r_lb1[r_icol] <= in_data;
      for (int i = 0; i < 3; i++) begin
        r_w[i][0] <= r_w[i][1];
        r_w[i][1] <= r_w[i][2];
      end
      r_w[0][2] <= r_lb0[r_icol];
      r_w[1][2] <= r_lb1[r_icol];
      r_w[2][2] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < 3; j++) begin
      r_mn[j] <= f_min3(r_w[0][j], r_w[1][j], r_w[2][j]);
      r_md[j] <= f_med3(r_w[0][j], r_w[1][j], r_w[2][j]);
      r_mx[j] <= f_max3(r_w[0][j], r_w[1][j], r_w[2][j]);
    end
    r_c1 <= r_w[1][1];
    r_a  <= f_max3(r_mn[0], r_mn[1], r_mn[2]);
    r_b  <= f_med3(r_md[0], r_md[1], r_md[2]);
    r_c  <= f_min3(r_mx[0], r_mx[1], r_mx[2]);
    r_c2 <= r_c1;
  end

  assign w_res = r_bord2 ? ((BORDER_MODE != 0) ? '0 : r_c2)
                         : f_med3(r_a, r_b, r_c);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_v1      <= 1'b0;
      r_sof1    <= 1'b0;
      r_eol1    <= 1'b0;
      r_bord1   <= 1'b0;
      r_v2      <= 1'b0;
      r_sof2    <= 1'b0;
      r_eol2    <= 1'b0;
      r_bord2   <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_data  <= '0;
    end else begin
      r_v1      <= r_req;
      r_sof1    <= r_req_sof;
      r_eol1    <= r_req_eol;
      r_bord1   <= r_req_bord;
      r_v2      <= r_v1;
      r_sof2    <= r_sof1;
      r_eol2    <= r_eol1;
      r_bord2   <= r_bord1;
      out_valid <= r_v2;
      out_sof   <= r_v2 & r_sof2;
      out_eol   <= r_v2 & r_eol2;
      if (r_v2)
        out_data <= w_res;
    end
  end

endmodule

// File: tb/tb_median3x3_stream.sv
// Directed bench for median3x3_stream on a 4x4 frame.
// Two instances share stimulus: passthrough borders and zeroed borders.
module tb_median3x3_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       rdy0, rdy1;
  logic       ov0, ov1, sof0, sof1, eol0, eol1;
  logic [7:0] od0, od1;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int cyc    = 0;
  int nacc   = 0;
  int last_wait = 0;
  int acc_cyc [64];

  int q_d[$], q_s[$], q_e[$], q_c[$], q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  median3x3_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .BORDER_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .out_valid(ov0), .out_data(od0),
    .out_sof(sof0), .out_eol(eol0)
  );

  median3x3_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .BORDER_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .out_valid(ov1), .out_data(od1),
    .out_sof(sof1), .out_eol(eol1)
  );

  always @(negedge clk) begin
    if (ov0) begin
      q_d.push_back(int'(od0));
      q_s.push_back(int'(sof0));
      q_e.push_back(int'(eol0));
      q_c.push_back(cyc);
    end
    if (ov1) q1.push_back(int'(od1));
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    q_d.delete(); q_s.delete(); q_e.delete(); q_c.delete(); q1.delete();
    nacc = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_px(input int d, input bit gap);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = 8'(d);
    while (!rdy0 && n < 50) begin
      tick(1);
      n++;
    end
    last_wait = n;
    if (n >= 50) chk("accept_timeout", n, 0);
    tick(1);
    acc_cyc[nacc % 64] = cyc;
    nacc++;
    if (gap) begin
      in_valid = 1'b0;
      tick(1);
    end
  endtask

  function automatic int px(input int kind, input int base, input int r, input int c);
    if (kind == 1) return base + r * 4 + c;
    if (kind == 2 && r == 1 && c == 1) return 255;
    return base;
  endfunction

  task automatic send_frame(input int kind, input int base, input bit gap, input bit hold);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        send_px(px(kind, base, r, c), gap);
    if (!hold) in_valid = 1'b0;
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic chk_frame(input string tag, input int off, input int kind, input int base);
    int e0, e1;
    for (int k = 0; k < 16; k++) begin
      int r, c;
      bit bord;
      r = k / 4;
      c = k % 4;
      bord = (r == 0) || (r == 3) || (c == 0) || (c == 3);
      e0 = (kind == 2) ? base : px(kind, base, r, c);
      e1 = bord ? 0 : e0;
      chk($sformatf("%s_d0_%0d", tag, k), qget(q_d, off + k), e0);
      chk($sformatf("%s_d1_%0d", tag, k), qget(q1, off + k), e1);
      chk($sformatf("%s_sof_%0d", tag, k), qget(q_s, off + k), (k == 0) ? 1 : 0);
      chk($sformatf("%s_eol_%0d", tag, k), qget(q_e, off + k), (c == 3) ? 1 : 0);
    end
  endtask

  initial begin
    int n;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    tick(3);
    chk("rst_in_ready", int'(rdy0), 0);
    chk("rst_out_valid", int'(ov0), 0);
    chk("rst_out_data", int'(od0), 0);
    chk("rst_sof_eol", int'({sof0, eol0}), 0);
    rst = 1'b1;
    tick(1);
    chk("rel_in_ready", int'(rdy0), 1);

    // 1: constant frame, latency and flush length
    clr();
    send_frame(0, 50, 1'b0, 1'b0);
    n = 0;
    while (!rdy0 && n < 20) begin
      tick(1);
      n++;
    end
    chk("t1_flush_len", n, 5);
    tick(10);
    chk("t1_count", q_d.size(), 16);
    chk("t1_latency", qget(q_c, 0) - acc_cyc[5], 3);
    for (int k = 0; k < 16; k++)
      chk($sformatf("t1_d_%0d", k), qget(q_d, k), 50);

    // 2: impulse rejection and framing flags
    clr();
    send_frame(2, 10, 1'b0, 1'b0);
    tick(12);
    chk("t2_count", q_d.size(), 16);
    chk_frame("t2", 0, 2, 10);

    // 3: ramp, zeroed borders on dut1
    clr();
    send_frame(1, 0, 1'b0, 1'b0);
    tick(12);
    chk("t3_count", q1.size(), 16);
    chk("t3_i11", qget(q1, 5), 5);
    chk("t3_i12", qget(q1, 6), 6);
    chk("t3_i21", qget(q1, 9), 9);
    chk("t3_i22", qget(q1, 10), 10);
    chk_frame("t3", 0, 1, 0);

    // 4: ramp with in_valid toggling
    clr();
    send_frame(1, 0, 1'b1, 1'b0);
    tick(12);
    chk("t4_count", q_d.size(), 16);
    chk_frame("t4", 0, 1, 0);

    // 5: second frame presented during flush
    clr();
    send_frame(1, 0, 1'b0, 1'b1);
    send_px(100, 1'b0);
    chk("t5_holdoff", last_wait, 5);
    for (int i = 1; i < 16; i++)
      send_px(px(1, 100, i / 4, i % 4), 1'b0);
    in_valid = 1'b0;
    tick(12);
    chk("t5_count", q_d.size(), 32);
    chk_frame("t5a", 0, 1, 0);
    chk_frame("t5b", 16, 1, 100);

    // 6: reset mid-frame, then fresh frame
    clr();
    for (int i = 0; i < 9; i++) send_px(200, 1'b0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick(1);
    chk("t6_rst_ready", int'(rdy0), 0);
    chk("t6_rst_valid", int'(ov0), 0);
    rst = 1'b1;
    clr();
    tick(1);
    chk("t6_rel_valid", int'(ov0), 0);
    send_frame(0, 77, 1'b0, 1'b0);
    tick(12);
    chk("t6_count", q_d.size(), 16);
    chk_frame("t6", 0, 0, 77);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
